// File: rtl/cpl_sched_pkg.sv
// Shared types and defaults for the completion request scheduler.
package cpl_sched_pkg;

  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 1024;

  typedef struct packed {
    logic        with_data;
    logic [2:0]  tc;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [9:0]  len;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [7:0]  be;
    logic [12:0] addr;
  } cpl_desc_t;

  localparam int DESC_W = $bits(cpl_desc_t);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/cpl_desc_fifo.sv
// Circular descriptor FIFO with a registered head word that reads 0 when empty.
module cpl_desc_fifo
  import cpl_sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DESC_W-1:0] wdata,
  output logic [DESC_W-1:0] head,
  output logic [CW-1:0]     count,
  output logic [CW-1:0]     count_nxt
);

  logic [DESC_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]     rd_ptr_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [CW-1:0]     count_r;
  logic [DESC_W-1:0] head_r;
  logic [PW-1:0]     rd_nxt_s;
  logic [CW-1:0]     count_nxt_s;
  logic [DESC_W-1:0] head_nxt_s;

  // Next read pointer, count and head word (bypass when the new head is being written now)
  always_comb begin
    rd_nxt_s    = rd_ptr_r;
    count_nxt_s = count_r;
    head_nxt_s  = {DESC_W{1'b0}};
    case ({push, pop})
      2'b10: count_nxt_s = count_r + CW'(1);
      2'b01: begin
        count_nxt_s = count_r - CW'(1);
        rd_nxt_s    = rd_ptr_r + PW'(1);
      end
      2'b11: rd_nxt_s = rd_ptr_r + PW'(1);
      default: count_nxt_s = count_r;
    endcase
    if (count_nxt_s == CW'(0)) begin
      head_nxt_s = {DESC_W{1'b0}};
    end else if (push && (rd_nxt_s == wr_ptr_r)) begin
      head_nxt_s = wdata;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // Pointer, count and head registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= PW'(0);
      wr_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      head_r   <= {DESC_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      rd_ptr_r <= rd_nxt_s;
      count_r  <= count_nxt_s;
      head_r   <= head_nxt_s;
    end
  end

  // Descriptor storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DESC_W{1'b0}};
      end
    end else if (push) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign head      = head_r;
  assign count     = count_r;
  assign count_nxt = count_nxt_s;

endmodule

// File: rtl/cpl_req_sched.sv
// Completion request scheduler: queues RX completion requests and issues them to TX one at a time.
module cpl_req_sched
  import cpl_sched_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_compl_i,
  input  logic        req_compl_with_data_i,
  input  logic [2:0]  req_tc_i,
  input  logic        req_td_i,
  input  logic        req_ep_i,
  input  logic [1:0]  req_attr_i,
  input  logic [9:0]  req_len_i,
  input  logic [15:0] req_rid_i,
  input  logic [7:0]  req_tag_i,
  input  logic [7:0]  req_be_i,
  input  logic [12:0] req_addr_i,
  output logic        to_rxe_compl_done_o,
  output logic        rx_np_ok_o,
  output logic        req_compl_o,
  output logic        req_compl_with_data_o,
  output logic [2:0]  req_tc_o,
  output logic        req_td_o,
  output logic        req_ep_o,
  output logic [1:0]  req_attr_o,
  output logic [9:0]  req_len_o,
  output logic [15:0] req_rid_o,
  output logic [7:0]  req_tag_o,
  output logic [7:0]  req_be_o,
  output logic [12:0] req_addr_o,
  input  logic        txe_compl_done_i,
  output logic        timeout_o,
  output logic        ovf_err_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  sched_state_t  state_r, state_nxt_s;
  logic [TW-1:0] timer_r;
  logic          push_s, pop_s, issue_s, timeout_s, ovf_s;
  logic          ack_r, np_ok_r, compl_r, cwd_r, timeout_r, ovf_r;
  cpl_desc_t     req_desc_s, head_s;
  logic [DESC_W-1:0] head_w;
  logic [CW-1:0] count_w, count_nxt_w;

  assign req_desc_s = {req_compl_with_data_i, req_tc_i, req_td_i, req_ep_i, req_attr_i,
                       req_len_i, req_rid_i, req_tag_i, req_be_i, req_addr_i};
  assign head_s = cpl_desc_t'(head_w);

  cpl_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .wdata     (req_desc_s),
    .head      (head_w),
    .count     (count_w),
    .count_nxt (count_nxt_w)
  );

  // Next state, pop/issue/timeout strobes and push admission
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    issue_s     = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (count_w != CW'(0)) begin
          state_nxt_s = ST_ISSUE;
          issue_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (txe_compl_done_i) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (timer_r == TMAX) begin
          pop_s       = 1'b1;
          timeout_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
    // A pop at the same edge frees the slot, so a full queue still accepts
    if (req_compl_i && ((count_w != CW'(DEPTH)) || pop_s)) begin
      push_s = 1'b1;
      ovf_s  = 1'b0;
    end else begin
      push_s = 1'b0;
      ovf_s  = req_compl_i;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // WAIT_DONE timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= TW'(0);
    end else if ((state_r == ST_WAIT_DONE) && !pop_s) begin
      timer_r <= timer_r + TW'(1);
    end else begin
      timer_r <= TW'(0);
    end
  end

  // Registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r     <= 1'b0;
      np_ok_r   <= 1'b1;
      compl_r   <= 1'b0;
      cwd_r     <= 1'b0;
      timeout_r <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      ack_r     <= push_s;
      np_ok_r   <= (count_nxt_w <= CW'(DEPTH - 2));
      compl_r   <= issue_s;
      cwd_r     <= issue_s & head_s.with_data;
      timeout_r <= timeout_s;
      ovf_r     <= ovf_r | ovf_s;
    end
  end

  assign to_rxe_compl_done_o   = ack_r;
  assign rx_np_ok_o            = np_ok_r;
  assign req_compl_o           = compl_r;
  assign req_compl_with_data_o = cwd_r;
  assign timeout_o             = timeout_r;
  assign ovf_err_o             = ovf_r;
  assign req_tc_o              = head_s.tc;
  assign req_td_o              = head_s.td;
  assign req_ep_o              = head_s.ep;
  assign req_attr_o            = head_s.attr;
  assign req_len_o             = head_s.len;
  assign req_rid_o             = head_s.rid;
  assign req_tag_o             = head_s.tag;
  assign req_be_o              = head_s.be;
  assign req_addr_o            = head_s.addr;

endmodule

// File: tb/tb_cpl_req_sched.sv
// Directed testbench for cpl_req_sched (DEPTH=4, TIMEOUT=16).
module tb_cpl_req_sched;
  import cpl_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_compl_i = 1'b0, req_compl_with_data_i = 1'b0;
  logic [2:0]  req_tc_i = 3'd0;
  logic        req_td_i = 1'b0, req_ep_i = 1'b0;
  logic [1:0]  req_attr_i = 2'd0;
  logic [9:0]  req_len_i = 10'd0;
  logic [15:0] req_rid_i = 16'd0;
  logic [7:0]  req_tag_i = 8'd0, req_be_i = 8'd0;
  logic [12:0] req_addr_i = 13'd0;
  logic        txe_compl_done_i = 1'b0;
  logic        to_rxe_compl_done_o, rx_np_ok_o, req_compl_o, req_compl_with_data_o;
  logic [2:0]  req_tc_o;
  logic        req_td_o, req_ep_o;
  logic [1:0]  req_attr_o;
  logic [9:0]  req_len_o;
  logic [15:0] req_rid_o;
  logic [7:0]  req_tag_o, req_be_o;
  logic [12:0] req_addr_o;
  logic        timeout_o, ovf_err_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpl_req_sched #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_compl_i(req_compl_i), .req_compl_with_data_i(req_compl_with_data_i),
    .req_tc_i(req_tc_i), .req_td_i(req_td_i), .req_ep_i(req_ep_i), .req_attr_i(req_attr_i),
    .req_len_i(req_len_i), .req_rid_i(req_rid_i), .req_tag_i(req_tag_i), .req_be_i(req_be_i),
    .req_addr_i(req_addr_i),
    .to_rxe_compl_done_o(to_rxe_compl_done_o), .rx_np_ok_o(rx_np_ok_o),
    .req_compl_o(req_compl_o), .req_compl_with_data_o(req_compl_with_data_o),
    .req_tc_o(req_tc_o), .req_td_o(req_td_o), .req_ep_o(req_ep_o), .req_attr_o(req_attr_o),
    .req_len_o(req_len_o), .req_rid_o(req_rid_o), .req_tag_o(req_tag_o), .req_be_o(req_be_o),
    .req_addr_o(req_addr_o),
    .txe_compl_done_i(txe_compl_done_i), .timeout_o(timeout_o), .ovf_err_o(ovf_err_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [7:0] tag, input logic [9:0] len, input logic [7:0] be,
                         input logic [12:0] addr, input logic wd);
    req_compl_i = 1'b1; req_compl_with_data_i = wd;
    req_tc_i = 3'd1; req_td_i = 1'b0; req_ep_i = 1'b0; req_attr_i = 2'd2;
    req_rid_i = 16'hBEEF; req_tag_i = tag; req_len_i = len; req_be_i = be; req_addr_i = addr;
  endtask

  task automatic clr_req;
    req_compl_i = 1'b0;
    req_compl_with_data_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_cmp++; if (req_compl_o !== 1'b0) begin n_err++; $display("FAIL rst_compl: got %b want 0", req_compl_o); end
    n_cmp++; if (to_rxe_compl_done_o !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", to_rxe_compl_done_o); end
    n_cmp++; if (timeout_o !== 1'b0 || ovf_err_o !== 1'b0) begin n_err++; $display("FAIL rst_flags: got to=%b ovf=%b want 0 0", timeout_o, ovf_err_o); end
    n_cmp++; if (rx_np_ok_o !== 1'b1) begin n_err++; $display("FAIL rst_np_ok: got %b want 1", rx_np_ok_o); end
    n_cmp++; if (req_tag_o !== 8'd0 || req_addr_o !== 13'd0 || req_rid_o !== 16'd0) begin n_err++; $display("FAIL rst_desc: got tag=%h addr=%h rid=%h want 0", req_tag_o, req_addr_o, req_rid_o); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single;
    set_req(8'd5, 10'd1, 8'h0F, 13'h10, 1'b1);
    tick; clr_req;
    n_cmp++; if (to_rxe_compl_done_o !== 1'b1 || req_compl_o !== 1'b0) begin n_err++; $display("FAIL single_ack: got ack=%b compl=%b want 1 0", to_rxe_compl_done_o, req_compl_o); end
    tick;
    n_cmp++; if (req_compl_o !== 1'b1 || req_compl_with_data_o !== 1'b1) begin n_err++; $display("FAIL single_issue: got compl=%b wd=%b want 1 1", req_compl_o, req_compl_with_data_o); end
    n_cmp++; if (req_tag_o !== 8'd5 || req_len_o !== 10'd1 || req_be_o !== 8'h0F || req_addr_o !== 13'h10 || req_rid_o !== 16'hBEEF) begin
      n_err++; $display("FAIL single_desc: got tag=%h len=%h be=%h addr=%h rid=%h want 05 001 0f 0010 beef", req_tag_o, req_len_o, req_be_o, req_addr_o, req_rid_o); end
    n_cmp++; if (to_rxe_compl_done_o !== 1'b0) begin n_err++; $display("FAIL single_ack_pulse: got %b want 0", to_rxe_compl_done_o); end
    txe_compl_done_i = 1'b1;  // arrives in ISSUE, must be ignored
    tick; txe_compl_done_i = 1'b0;
    n_cmp++; if (req_compl_o !== 1'b0 || dut.u_fifo.count_r !== 3'd1 || dut.state_r !== ST_WAIT_DONE) begin
      n_err++; $display("FAIL single_wait: got compl=%b count=%0d state=%0d want 0 1 2", req_compl_o, dut.u_fifo.count_r, dut.state_r); end
    repeat (9) tick;
    n_cmp++; if (req_tag_o !== 8'd5) begin n_err++; $display("FAIL single_stable: got tag=%h want 05", req_tag_o); end
    txe_compl_done_i = 1'b1;
    tick; txe_compl_done_i = 1'b0;
    n_cmp++; if (dut.state_r !== ST_IDLE || dut.u_fifo.count_r !== 3'd0) begin n_err++; $display("FAIL single_done: got state=%0d count=%0d want 0 0", dut.state_r, dut.u_fifo.count_r); end
    n_cmp++; if (req_tag_o !== 8'd0 || req_addr_o !== 13'd0 || rx_np_ok_o !== 1'b1) begin n_err++; $display("FAIL single_empty: got tag=%h addr=%h np=%b want 0 0 1", req_tag_o, req_addr_o, rx_np_ok_o); end
    tick;
  endtask

  task automatic test_overflow;
    logic exp_ack [5];
    logic exp_np  [5];
    exp_ack = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_np  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      set_req(8'(i + 1), 10'd4, 8'hFF, 13'(i * 16), i[0]);
      tick;
      n_cmp++; if (to_rxe_compl_done_o !== exp_ack[i]) begin n_err++; $display("FAIL ovf_ack[%0d]: got %b want %b", i, to_rxe_compl_done_o, exp_ack[i]); end
      n_cmp++; if (rx_np_ok_o !== exp_np[i]) begin n_err++; $display("FAIL ovf_np_ok[%0d]: got %b want %b", i, rx_np_ok_o, exp_np[i]); end
      if (i == 1) begin
        n_cmp++; if (req_compl_o !== 1'b1 || req_tag_o !== 8'd1 || req_compl_with_data_o !== 1'b0) begin
          n_err++; $display("FAIL ovf_first_issue: got compl=%b tag=%h wd=%b want 1 01 0", req_compl_o, req_tag_o, req_compl_with_data_o); end
      end
    end
    clr_req;
    n_cmp++; if (ovf_err_o !== 1'b1 || dut.u_fifo.count_r !== 3'd4) begin n_err++; $display("FAIL ovf_flag: got ovf=%b count=%0d want 1 4", ovf_err_o, dut.u_fifo.count_r); end
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp_tag [4];
    logic       exp_wd  [4];
    int n;
    exp_tag = '{8'd2, 8'd3, 8'd4, 8'd6};
    exp_wd  = '{1'b1, 1'b0, 1'b1, 1'b1};
    set_req(8'd6, 10'd2, 8'h3C, 13'h1F0, 1'b1);
    txe_compl_done_i = 1'b1;
    tick; clr_req; txe_compl_done_i = 1'b0;
    n_cmp++; if (dut.u_fifo.count_r !== 3'd4 || to_rxe_compl_done_o !== 1'b1 || req_tag_o !== 8'd2) begin
      n_err++; $display("FAIL full_pushpop: got count=%0d ack=%b head=%h want 4 1 02", dut.u_fifo.count_r, to_rxe_compl_done_o, req_tag_o); end
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (req_compl_o !== 1'b1 && n < 20) begin tick; n++; end
      n_cmp++;
      if (n >= 20) begin
        n_err++; $display("FAIL drain_wait[%0d]: got no req_compl_o in 20 cycles want issue", k);
      end else if (req_tag_o !== exp_tag[k] || req_compl_with_data_o !== exp_wd[k]) begin
        n_err++; $display("FAIL drain_issue[%0d]: got tag=%h wd=%b want %h %b", k, req_tag_o, req_compl_with_data_o, exp_tag[k], exp_wd[k]);
      end
      tick;
      txe_compl_done_i = 1'b1;
      tick; txe_compl_done_i = 1'b0;
      n_cmp++; if (req_compl_o !== 1'b0) begin n_err++; $display("FAIL drain_gap[%0d]: got compl=%b want 0", k, req_compl_o); end
    end
    n_cmp++; if (dut.u_fifo.count_r !== 3'd0) begin n_err++; $display("FAIL drain_empty: got count=%0d want 0", dut.u_fifo.count_r); end
  endtask

  task automatic test_timeout;
    int bad;
    tick;
    set_req(8'd8, 10'd3, 8'h01, 13'h20, 1'b0);
    tick;
    set_req(8'd9, 10'd5, 8'h02, 13'h30, 1'b1);
    tick; clr_req;
    n_cmp++; if (req_compl_o !== 1'b1 || req_tag_o !== 8'd8) begin n_err++; $display("FAIL to_issue: got compl=%b tag=%h want 1 08", req_compl_o, req_tag_o); end
    tick;
    bad = 0;
    repeat (15) begin tick; if (timeout_o !== 1'b0) bad++; end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL to_early: got %0d early pulses want 0", bad); end
    tick;
    n_cmp++; if (timeout_o !== 1'b1 || req_compl_o !== 1'b0 || dut.u_fifo.count_r !== 3'd1) begin
      n_err++; $display("FAIL to_pulse: got to=%b compl=%b count=%0d want 1 0 1", timeout_o, req_compl_o, dut.u_fifo.count_r); end
    tick;
    n_cmp++; if (timeout_o !== 1'b0 || req_compl_o !== 1'b1 || req_tag_o !== 8'd9) begin
      n_err++; $display("FAIL to_next: got to=%b compl=%b tag=%h want 0 1 09", timeout_o, req_compl_o, req_tag_o); end
  endtask

  task automatic test_done_on_timeout;
    tick;
    repeat (15) tick;
    n_cmp++; if (timeout_o !== 1'b0 || dut.state_r !== ST_WAIT_DONE) begin n_err++; $display("FAIL dto_pre: got to=%b state=%0d want 0 2", timeout_o, dut.state_r); end
    txe_compl_done_i = 1'b1;
    tick; txe_compl_done_i = 1'b0;
    n_cmp++; if (timeout_o !== 1'b0 || dut.u_fifo.count_r !== 3'd0 || dut.state_r !== ST_IDLE) begin
      n_err++; $display("FAIL dto_pop: got to=%b count=%0d state=%0d want 0 0 0", timeout_o, dut.u_fifo.count_r, dut.state_r); end
    tick;
    n_cmp++; if (timeout_o !== 1'b0 || req_compl_o !== 1'b0) begin n_err++; $display("FAIL dto_after: got to=%b compl=%b want 0 0", timeout_o, req_compl_o); end
  endtask

  task automatic test_reset_mid;
    int bad;
    for (int i = 0; i < 3; i++) begin
      set_req(8'(10 + i), 10'd1, 8'hAA, 13'(i), 1'b1);
      tick;
    end
    clr_req;
    tick;
    n_cmp++; if (dut.state_r !== ST_WAIT_DONE || dut.u_fifo.count_r !== 3'd3) begin n_err++; $display("FAIL rm_setup: got state=%0d count=%0d want 2 3", dut.state_r, dut.u_fifo.count_r); end
    rst_n = 1'b0;
    #2;
    n_cmp++; if (req_compl_o !== 1'b0 || to_rxe_compl_done_o !== 1'b0 || timeout_o !== 1'b0 || ovf_err_o !== 1'b0) begin
      n_err++; $display("FAIL rm_pulses: got compl=%b ack=%b to=%b ovf=%b want 0 0 0 0", req_compl_o, to_rxe_compl_done_o, timeout_o, ovf_err_o); end
    n_cmp++; if (rx_np_ok_o !== 1'b1 || req_tag_o !== 8'd0 || dut.u_fifo.count_r !== 3'd0 || dut.state_r !== ST_IDLE) begin
      n_err++; $display("FAIL rm_state: got np=%b tag=%h count=%0d state=%0d want 1 00 0 0", rx_np_ok_o, req_tag_o, dut.u_fifo.count_r, dut.state_r); end
    tick; tick;
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      tick;
      if (req_compl_o !== 1'b0 || timeout_o !== 1'b0 || to_rxe_compl_done_o !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rm_quiet: got %0d active cycles want 0", bad); end
    set_req(8'd13, 10'd7, 8'h55, 13'h7, 1'b0);
    tick; clr_req;
    tick;
    n_cmp++; if (req_compl_o !== 1'b1 || req_tag_o !== 8'd13) begin n_err++; $display("FAIL rm_new: got compl=%b tag=%h want 1 0d", req_compl_o, req_tag_o); end
    tick;
    txe_compl_done_i = 1'b1;
    tick; txe_compl_done_i = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_overflow;
    test_full_push_pop;
    test_timeout;
    test_done_on_timeout;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpl_req_sched.md
CPL_REQ_SCHED -- requirements
Module: cpl_req_sched

Interface
REQ-001 The parameter DEPTH SHALL default to 4 and set the number of queued completion requests; it SHALL be a power of 2 and at least 2.
REQ-002 The parameter TIMEOUT SHALL default to 1024 and set the cycles allowed in WAIT_DONE before the head entry is dropped.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_compl_i  input  1  one-cycle pulse from the RX engine requesting a completion.
REQ-006 req_compl_with_data_i  input  1  the requested completion carries data (CplD).
REQ-007 req_tc_i 3, req_td_i 1, req_ep_i 1, req_attr_i 2, req_len_i 10, req_rid_i 16, req_tag_i 8, req_be_i 8, req_addr_i 13  inputs  request descriptor fields, valid with req_compl_i.
REQ-008 to_rxe_compl_done_o  output  1  one-cycle pulse acknowledging that the request was accepted into the queue.
REQ-009 rx_np_ok_o  output  1  the RX engine may accept another non-posted TLP.
REQ-010 req_compl_o, req_compl_with_data_o  outputs  1  completion request to the TX engine, with its data flag.
REQ-011 req_tc_o .. req_addr_o  outputs  same widths as the inputs  head-entry descriptor to the TX engine.
REQ-012 txe_compl_done_i  input  1  one-cycle pulse from the TX engine signalling that the completion has been sent.
REQ-013 timeout_o  output  1  one-cycle pulse when the head entry is dropped on timeout.
REQ-014 ovf_err_o  output  1  sticky flag: a request was dropped because the queue was full.

Function
REQ-015 Request storage SHALL be a circular FIFO of DEPTH 63-bit descriptors (data flag plus all req_* fields), using wrap-around read/write pointers and a count of width log2(DEPTH)+1.
REQ-016 Push: when req_compl_i is sampled high and count < DEPTH, the descriptor SHALL be written at that edge, and to_rxe_compl_done_o SHALL be high for the following cycle.
REQ-017 Push when full: when req_compl_i is high and count == DEPTH, the request SHALL be discarded, no acknowledge SHALL be given, and ovf_err_o SHALL be set.
REQ-018 A push and a pop at the same edge SHALL leave count unchanged; both SHALL be honoured even when the queue is full or holds one entry.
REQ-019 rx_np_ok_o SHALL be registered and SHALL equal (count <= DEPTH-2), keeping one slot of headroom for a TLP already in flight.
REQ-020 The FSM SHALL have the states IDLE, ISSUE and WAIT_DONE.
REQ-021 IDLE -> ISSUE when count != 0; otherwise the FSM SHALL stay in IDLE.
REQ-022 ISSUE: req_compl_o SHALL be high for exactly this one cycle, and req_compl_with_data_o SHALL equal the head entry's data flag; the next state SHALL be WAIT_DONE.
REQ-023 WAIT_DONE: txe_compl_done_i SHALL pop the head entry, clear the timer and return the FSM to IDLE.
REQ-024 The timer SHALL increment each cycle in WAIT_DONE; when it reaches TIMEOUT-1 without done, the head entry SHALL be popped, timeout_o SHALL pulse, and the FSM SHALL return to IDLE.
REQ-025 If done and timeout occur in the same cycle, done SHALL take priority and timeout_o SHALL stay low.
REQ-026 A txe_compl_done_i seen in IDLE or ISSUE SHALL be ignored.
REQ-027 Latency: a request sampled at edge E0 into an empty, idle queue SHALL produce req_compl_o in the cycle after E1; back-to-back completions SHALL be spaced by at least one IDLE cycle.
REQ-028 The descriptor outputs SHALL reflect the head entry and SHALL be stable from ISSUE until the pop.
REQ-029 The descriptor outputs SHALL read 0 when the queue is empty.

Reset
REQ-030 While rst_n is low, pointers, count and timer SHALL be 0; the FSM SHALL be in IDLE; and req_compl_o, req_compl_with_data_o, to_rxe_compl_done_o, timeout_o and ovf_err_o SHALL be 0.
REQ-031 While rst_n is low, rx_np_ok_o SHALL be 1 and all descriptor outputs SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard all queued and in-flight entries without emitting any pulse.

Structure
REQ-033 The package cpl_sched_pkg SHALL hold the descriptor struct type, the FSM state enum, and the DEPTH and TIMEOUT defaults.
REQ-034 The FIFO SHALL be the sub-module cpl_desc_fifo (storage, pointers, count); cpl_req_sched SHALL hold the FSM, the timer and the flags.

Verification
REQ-035 Single request tag=5, len=1, be=8'h0F, addr=13'h10, with data -> ack the next cycle; req_compl_o one cycle later with matching fields; done after 10 cycles -> IDLE, count=0.
REQ-036 Five pushes on consecutive cycles with DEPTH=4 and no done -> 4 acks; rx_np_ok_o falls when count reaches 3; ovf_err_o=1; tag 5 never issued.
REQ-037 Queue full plus a done and a push at the same edge -> count stays 4, the new entry is accepted, and the next issued tag is the second entry's.
REQ-038 Issue with no done and TIMEOUT=16 -> timeout_o pulses 16 cycles after entering WAIT_DONE; the next entry is issued after one IDLE cycle.
REQ-039 done arriving on the timeout cycle -> no timeout_o pulse; normal pop.
REQ-040 rst_n low while in WAIT_DONE with 3 entries queued -> all outputs at reset values; no req_compl_o after release until a new push.
